// File: rtl/calc_pkg.sv
// Shared constants and types for the register-mapped 4-bit calculator.
package calc_pkg;

  localparam logic [6:0] ADDR_OPA    = 7'h00;
  localparam logic [6:0] ADDR_OPB    = 7'h01;
  localparam logic [6:0] ADDR_CTRL   = 7'h02;
  localparam logic [6:0] ADDR_STATUS = 7'h03;
  localparam logic [6:0] ADDR_RESULT = 7'h04;
  localparam logic [6:0] ADDR_REM    = 7'h05;
  localparam logic [6:0] ADDR_ID     = 7'h7F;

  localparam logic [7:0] CALC_ID = 8'hC4;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Operations that finish in a single RUN cycle.
  function automatic logic op_is_short(op_e op, logic [3:0] b);
    return (op == OP_ADD) || (op == OP_SUB) || ((op == OP_DIV) && (b == 4'd0));
  endfunction

endpackage

// File: rtl/calc_core.sv
// Iterative arithmetic datapath: operand latches, iteration counter,
// shift-and-add multiplier and restoring divider.
module calc_core
  import calc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       step,
  input  op_e        op,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       last,
  output logic [7:0] res,
  output logic [3:0] rem,
  output logic       carry,
  output logic       div0
);

  op_e        op_q;
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic [1:0] cnt;
  logic [7:0] acc;
  logic [3:0] part;
  logic [3:0] quo;

  logic [4:0] sum;
  logic [4:0] diff;
  logic [7:0] acc_nxt;
  logic [4:0] shifted;
  logic [3:0] part_nxt;
  logic [3:0] quo_nxt;
  logic       qbit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q <= OP_ADD;
      a_q  <= '0;
      b_q  <= '0;
      cnt  <= '0;
      acc  <= '0;
      part <= '0;
      quo  <= '0;
    end else if (load) begin
      op_q <= op;
      a_q  <= a;
      b_q  <= b;
      cnt  <= '0;
      acc  <= '0;
      part <= '0;
      quo  <= '0;
    end else if (step) begin
      cnt  <= cnt + 2'd1;
      acc  <= acc_nxt;
      part <= part_nxt;
      quo  <= quo_nxt;
    end
  end

  always_comb begin
    sum     = {1'b0, a_q} + {1'b0, b_q};
    diff    = {1'b0, a_q} - {1'b0, b_q};
    acc_nxt = acc + (b_q[cnt] ? ({4'b0, a_q} << cnt) : 8'h00);

    // Dividend bits enter MSB first; partial remainder never exceeds 4 bits after restore.
    shifted = {part, a_q[2'd3 - cnt]};
    if (shifted >= {1'b0, b_q}) begin
      part_nxt = 4'(shifted - {1'b0, b_q});
      qbit     = 1'b1;
    end else begin
      part_nxt = shifted[3:0];
      qbit     = 1'b0;
    end
    quo_nxt = {quo[2:0], qbit};

    last = op_is_short(op_q, b_q) || (cnt == 2'd3);

    res   = '0;
    rem   = '0;
    carry = 1'b0;
    div0  = 1'b0;
    case (op_q)
      OP_ADD: begin
        res   = {3'b0, sum};
        carry = sum[4];
      end
      OP_SUB: begin
        res   = {{3{diff[4]}}, diff};
        carry = diff[4];
      end
      OP_MUL: begin
        res = acc_nxt;
      end
      OP_DIV: begin
        if (b_q == 4'd0) begin
          res  = 8'hFF;
          rem  = a_q;
          div0 = 1'b1;
        end else begin
          res = {4'b0, quo_nxt};
          rem = part_nxt;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/calc_regfile.sv
// Register file front-end for the calculator: address decode, read-back
// path and IDLE/RUN sequencing around calc_core.
module calc_regfile
  import calc_pkg::*;
(
  input  logic       sclk,
  input  logic       rst,
  input  logic       write_vld,
  input  logic       read_en,
  input  logic [6:0] addr,
  input  logic [7:0] data_w,
  output logic [7:0] data_r,
  output logic       busy
);

  state_e     state;
  logic [3:0] opa;
  logic [3:0] opb;
  op_e        op;
  logic [7:0] result;
  logic [3:0] rem;
  logic       done;
  logic       div0;
  logic       carry;

  logic       start_acc;
  logic       rd_result;
  logic       run;
  logic       core_last;
  logic [7:0] core_res;
  logic [3:0] core_rem;
  logic       core_carry;
  logic       core_div0;
  logic [7:0] rd_data;
  logic       unused_bits;

  assign unused_bits = ^data_w[6:4];
  assign run         = (state == ST_RUN);
  assign start_acc   = write_vld && (addr == ADDR_CTRL) && data_w[7] && (state == ST_IDLE);
  assign rd_result   = read_en && (addr == ADDR_RESULT);

  calc_core u_core (
    .clk   (sclk),
    .rst   (rst),
    .load  (start_acc),
    .step  (run),
    .op    (op_e'(data_w[1:0])),
    .a     (opa),
    .b     (opb),
    .last  (core_last),
    .res   (core_res),
    .rem   (core_rem),
    .carry (core_carry),
    .div0  (core_div0)
  );

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      opa    <= '0;
      opb    <= '0;
      op     <= OP_ADD;
      data_r <= '0;
    end else begin
      if (write_vld) begin
        case (addr)
          ADDR_OPA:  opa <= data_w[3:0];
          ADDR_OPB:  opb <= data_w[3:0];
          ADDR_CTRL: op  <= op_e'(data_w[1:0]);
          default: ;
        endcase
      end
      if (read_en) data_r <= rd_data;
    end
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      div0   <= 1'b0;
      carry  <= 1'b0;
      result <= '0;
      rem    <= '0;
    end else begin
      // A RESULT read clears done unless completion lands on the same edge.
      if (rd_result) done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_acc) begin
            state <= ST_RUN;
            busy  <= 1'b1;
            done  <= 1'b0;
            div0  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (core_last) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= core_res;
            rem    <= core_rem;
            carry  <= core_carry;
            div0   <= core_div0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      ADDR_OPA:    rd_data = {4'b0, opa};
      ADDR_OPB:    rd_data = {4'b0, opb};
      ADDR_CTRL:   rd_data = {6'b0, op};
      ADDR_STATUS: rd_data = {4'b0, carry, div0, done, busy};
      ADDR_RESULT: rd_data = result;
      ADDR_REM:    rd_data = {4'b0, rem};
      ADDR_ID:     rd_data = CALC_ID;
      default:     rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_calc_regfile.sv
// Bench for calc_regfile: cycle-level behavioural model plus directed
// literal checks and a randomized register-traffic phase.
module tb_calc_regfile;

  logic       sclk = 1'b0;
  logic       rst = 1'b0;
  logic       write_vld = 1'b0;
  logic       read_en = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] data_w = '0;
  logic [7:0] data_r;
  logic       busy;

  calc_regfile dut (
    .sclk      (sclk),
    .rst       (rst),
    .write_vld (write_vld),
    .read_en   (read_en),
    .addr      (addr),
    .data_w    (data_w),
    .data_r    (data_r),
    .busy      (busy)
  );

  always #5 sclk = ~sclk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  int m_opa = 0, m_opb = 0, m_op = 0;
  int m_result = 0, m_rem = 0, m_done = 0, m_div0 = 0, m_carry = 0;
  int m_busy = 0, m_left = 0, m_la = 0, m_lb = 0, m_lop = 0, m_data_r = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int m_read(int a);
    case (a)
      0:       return m_opa;
      1:       return m_opb;
      2:       return m_op;
      3:       return m_carry * 8 + m_div0 * 4 + m_done * 2 + m_busy;
      4:       return m_result;
      5:       return m_rem;
      127:     return 196;
      default: return 0;
    endcase
  endfunction

  // Model: state as plain integers; duration and results from arithmetic.
  initial begin : model
    int rd;
    bit fin;
    forever begin
      @(posedge sclk or posedge rst);
      if (rst) begin
        m_opa = 0; m_opb = 0; m_op = 0; m_result = 0; m_rem = 0;
        m_done = 0; m_div0 = 0; m_carry = 0; m_busy = 0; m_left = 0; m_data_r = 0;
      end else begin
        rd  = m_read(int'(addr));
        fin = 1'b0;
        if (m_busy != 0) begin
          m_left--;
          if (m_left == 0) fin = 1'b1;
        end
        if (write_vld) begin
          case (int'(addr))
            0: m_opa = int'(data_w) % 16;
            1: m_opb = int'(data_w) % 16;
            2: begin
              m_op = int'(data_w) % 4;
              if (data_w[7] && m_busy == 0) begin
                m_la = m_opa; m_lb = m_opb; m_lop = m_op;
                m_busy = 1; m_done = 0; m_div0 = 0;
                m_left = (m_lop >= 2 && !(m_lop == 3 && m_lb == 0)) ? 4 : 1;
              end
            end
            default: ;
          endcase
        end
        if (fin) begin
          m_busy = 0;
          m_done = 1;
          m_rem = 0;
          m_carry = 0;
          case (m_lop)
            0: begin m_result = m_la + m_lb; m_carry = (m_la + m_lb > 15) ? 1 : 0; end
            1: begin m_result = (m_la - m_lb) & 255; m_carry = (m_la < m_lb) ? 1 : 0; end
            2: m_result = m_la * m_lb;
            default: begin
              if (m_lb == 0) begin m_result = 255; m_rem = m_la; m_div0 = 1; end
              else begin m_result = m_la / m_lb; m_rem = m_la % m_lb; end
            end
          endcase
        end else if (read_en && addr == 7'h04) begin
          m_done = 0;
        end
        if (read_en) m_data_r = rd;
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge sclk);
      if (!rst && chk_on) begin
        check("data_r", data_r, m_data_r);
        check("busy", busy, m_busy);
      end
    end
  end

  task automatic drive(input logic we, input logic re, input logic [6:0] a, input logic [7:0] d);
    @(negedge sclk);
    write_vld = we; read_en = re; addr = a; data_w = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 7'h00, 8'h00);
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    drive(1'b1, 1'b0, a, d);
  endtask

  task automatic rd_lit(input logic [6:0] a, input logic [7:0] exp, input string name);
    drive(1'b0, 1'b1, a, 8'h00);
    drive(1'b0, 1'b0, 7'h00, 8'h00);
    check(name, data_r, exp);
    check({name, "_model"}, m_data_r, exp);
  endtask

  task automatic run_op(input logic [7:0] ctrl, input int exp_cycles, input string name);
    int n = 0;
    wr(7'h02, ctrl);
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b0, 7'h00, 8'h00);
      if (busy) n++;
      else break;
    end
    check({name, "_busy_cycles"}, n, exp_cycles);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [6:0] ra;
    logic [7:0] rdat;
    #1 rst = 1'b1;
    repeat (3) @(negedge sclk);
    rst = 1'b0;
    chk_on = 1'b1;

    rd_lit(7'h00, 8'h00, "rst_opa");
    rd_lit(7'h03, 8'h00, "rst_status");
    rd_lit(7'h04, 8'h00, "rst_result");
    rd_lit(7'h7F, 8'hC4, "id");
    rd_lit(7'h10, 8'h00, "unmapped");

    wr(7'h00, 8'h09); wr(7'h01, 8'h07);
    run_op(8'h80, 1, "add");
    rd_lit(7'h03, 8'h0A, "add_status");
    rd_lit(7'h04, 8'h10, "add_result");
    rd_lit(7'h03, 8'h08, "status_done_cleared");

    wr(7'h00, 8'h03); wr(7'h01, 8'h05);
    run_op(8'h81, 1, "sub");
    rd_lit(7'h03, 8'h0A, "sub_status");
    rd_lit(7'h04, 8'hFE, "sub_result");

    wr(7'h00, 8'h0F); wr(7'h01, 8'h0F);
    run_op(8'h82, 4, "mul");
    rd_lit(7'h03, 8'h02, "mul_status");
    rd_lit(7'h04, 8'hE1, "mul_result");

    wr(7'h02, 8'h82);
    wr(7'h02, 8'h80);
    wr(7'h00, 8'h01);
    idle(6);
    rd_lit(7'h04, 8'hE1, "restart_ignored");
    rd_lit(7'h02, 8'h00, "ctrl_op_updated");
    rd_lit(7'h00, 8'h01, "opa_write_in_run");

    wr(7'h00, 8'h02); wr(7'h01, 8'h03);
    wr(7'h02, 8'h80);
    drive(1'b0, 1'b1, 7'h04, 8'h00);
    drive(1'b0, 1'b0, 7'h00, 8'h00);
    check("read_at_completion_old", data_r, 8'hE1);
    rd_lit(7'h03, 8'h02, "done_wins");
    rd_lit(7'h04, 8'h05, "add2_result");

    wr(7'h00, 8'h0D); wr(7'h01, 8'h04);
    run_op(8'h83, 4, "div");
    rd_lit(7'h04, 8'h03, "div_result");
    rd_lit(7'h05, 8'h01, "div_rem");

    wr(7'h01, 8'h00);
    run_op(8'h83, 1, "div0");
    rd_lit(7'h03, 8'h06, "div0_status");
    rd_lit(7'h04, 8'hFF, "div0_result");
    rd_lit(7'h05, 8'h0D, "div0_rem");
    rd_lit(7'h03, 8'h04, "div0_status_after_read");

    drive(1'b1, 1'b1, 7'h00, 8'h07);
    drive(1'b0, 1'b0, 7'h00, 8'h00);
    check("rw_same_cycle_prewrite", data_r, 8'h0D);
    rd_lit(7'h00, 8'h07, "rw_same_cycle_written");

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0: ra = 7'h00;
        1: ra = 7'h01;
        2, 7: ra = 7'h02;
        3: ra = 7'h03;
        4, 8: ra = 7'h04;
        5: ra = 7'h05;
        6: ra = 7'h7F;
        default: ra = 7'($urandom);
      endcase
      rdat = 8'($urandom);
      drive(1'($urandom), 1'($urandom), ra, rdat);
    end
    idle(8);

    wr(7'h00, 8'h0F); wr(7'h01, 8'h0F);
    wr(7'h02, 8'h82);
    idle(2);
    #2 rst = 1'b1;
    #1;
    check("rst_busy_async", busy, 1'b0);
    check("rst_data_r_async", data_r, 8'h00);
    repeat (2) @(negedge sclk);
    rst = 1'b0;
    idle(6);
    rd_lit(7'h00, 8'h00, "post_rst_opa");
    rd_lit(7'h01, 8'h00, "post_rst_opb");
    rd_lit(7'h02, 8'h00, "post_rst_ctrl");
    rd_lit(7'h03, 8'h00, "post_rst_status");
    rd_lit(7'h04, 8'h00, "post_rst_result");
    rd_lit(7'h05, 8'h00, "post_rst_rem");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/calc_regfile.md
CALC_REGFILE -- requirements
Module: calc_regfile

Interface
REQ-001 SHALL have port sclk, input, 1, free-running system clock; all logic rising-edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port write_vld, input, 1, single-cycle write strobe from the SPI slave, synchronous to sclk.
REQ-004 SHALL have port read_en, input, 1, read request from the SPI slave, synchronous to sclk.
REQ-005 SHALL have port addr, input, 7, register address.
REQ-006 SHALL have port data_w, input, 8, write data.
REQ-007 SHALL have port data_r, output, 8, registered read data returned to the SPI slave.
REQ-008 SHALL have port busy, output, 1, a calculation is in progress.

Function
REQ-009 SHALL implement this register map:
- 0x00 OPA: [3:0], RW.
- 0x01 OPB: [3:0], RW.
- 0x02 CTRL: [1:0] op (00 add, 01 sub, 10 mul, 11 div), RW; [7] start, write-1 pulse, reads 0.
- 0x03 STATUS: RO; [0] busy, [1] done, [2] div0, [3] carry.
- 0x04 RESULT: [7:0], RO.
- 0x05 REM: [3:0], RO.
- 0x7F ID: RO, 0xC4.
REQ-010 SHALL read unmapped addresses as 0x00, ignore writes to them, and read unused bits as 0.
REQ-011 SHALL load data_r on the sclk edge where read_en=1 (latency 1 cycle) and hold it otherwise.
REQ-012 SHALL, when write_vld and read_en coincide, apply the write and return the pre-write value.
REQ-013 SHALL use a two-state FSM: IDLE and RUN.
REQ-014 SHALL start from IDLE when CTRL is written with bit7=1: latch OPA, OPB and op, enter RUN, and raise busy on the next cycle.
REQ-015 SHALL ignore a start while in RUN; the op field still updates, and OPA/OPB writes are always accepted, without affecting the latched copies.
REQ-016 SHALL run add/sub for 1 RUN cycle and mul/div for exactly 4 RUN cycles, driven by a 2-bit iteration counter.
REQ-017 SHALL compute add as RESULT = {3'b0, A+B} (5-bit sum), with carry = bit4.
REQ-018 SHALL compute sub as RESULT = 8-bit sign-extended A-B, with carry = borrow.
REQ-019 SHALL compute mul by shift-and-add, RESULT = A*B (8-bit), with carry = 0.
REQ-020 SHALL compute div by restoring division, RESULT = {4'b0, A/B}, REM = A%B.
REQ-021 SHALL handle division by zero in 1 RUN cycle: RESULT=0xFF, REM=A, div0=1.
REQ-022 SHALL, on leaving RUN, update RESULT/REM/flags in the same edge, set done=1, drop busy, and return to IDLE.
REQ-023 SHALL clear done and div0 on a new accepted start.
REQ-024 SHALL clear done on a read of RESULT; if completion coincides with that read, done=1 wins.
REQ-025 SHALL update RESULT, REM and flags only at completion; they hold between operations.

Reset
REQ-026 SHALL, on rst, asynchronously clear OPA, OPB, CTRL, RESULT, REM, flags, counter and data_r to 0, set busy=0, and put the FSM in IDLE.
REQ-027 SHALL abandon any operation in progress on rst mid-operation, with no completion update after reset release.

Structure
REQ-028 SHALL place register addresses, opcode encodings, FSM state type and the ID constant in shared package calc_pkg.
REQ-029 SHALL place the iterative arithmetic datapath (operand latches, counter, shift-add, restoring divide) in sub-module calc_core, with the register decode and FSM control kept in calc_regfile.

Verification
REQ-030 SHALL cover add: OPA=0x9, OPB=0x7, CTRL=0x80 -> busy high 1 cycle, RESULT=0x10, STATUS=0x0A.
REQ-031 SHALL cover sub: OPA=0x3, OPB=0x5, CTRL=0x81 -> RESULT=0xFE, carry=1.
REQ-032 SHALL cover mul: OPA=0xF, OPB=0xF, CTRL=0x82 -> busy exactly 4 cycles, RESULT=0xE1.
REQ-033 SHALL cover div:
- OPA=0xD, OPB=0x4, CTRL=0x83 -> RESULT=0x03, REM=0x1.
- OPB=0x0 -> RESULT=0xFF, REM=0xD, div0=1.
REQ-034 SHALL cover start during busy and reset:
- CTRL=0x80 written while a mul is running -> ignored, mul result intact.
- rst asserted mid-mul -> busy=0 immediately, all registers read 0x00.
REQ-035 SHALL cover read paths:
- Read 0x7F -> 0xC4; read 0x10 -> 0x00.
- Read RESULT -> done clears, STATUS bit1=0.
